dbg_dispatch: RTL and testbench
===============================

# dbg_dispatch

Multi-target debug command dispatcher sitting between the host-side command decoder and N debuggable units. Host requests are queued in a request FIFO and issued one at a time on per-target cmd/addr/data/done channels. The block waits for the target's done with a bounded timeout, then returns a single response carrying read data and a status code. It generalises the single-target debug channel to N targets, adds queuing, timeout and error reporting.

## Interface
- BITSIZE, 32, address/data width
- N_TARGETS, 2, number of debug targets (≥1)
- FIFO_DEPTH, 4, request FIFO entries (power of two, ≥2)
- TIMEOUT, 255, maximum cycles spent in WAIT or in RELEASE (≥2)
- TW = max(1, $clog2(N_TARGETS)), derived
- clk  in  1  clock; all logic on the rising edge
- rstn_i  in  1  synchronous, active-low reset
- req_valid_i  in  1  host request valid
- req_ready_o  out  1  request FIFO not full
- req_target_i  in  TW  target index
- req_cmd_i  in  8  command; 0x00 is reserved (idle)
- req_addr_i  in  BITSIZE  address
- req_data_i  in  BITSIZE  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  host accepts response
- rsp_target_o  out  TW  target of this response
- rsp_status_o  out  2  00 OK, 01 timeout, 10 invalid request
- rsp_data_o  out  BITSIZE  data captured from the target
- dbg_cmd_o  out  8*N_TARGETS  per-target cmd; slice i = [8*i+:8]
- dbg_addr_o  out  BITSIZE*N_TARGETS  per-target address
- dbg_data_o  out  BITSIZE*N_TARGETS  per-target data to target
- dbg_data_i  in  BITSIZE*N_TARGETS  per-target data from target
- dbg_done_i  in  N_TARGETS  per-target done

## Operation
- Request FIFO: push on req_valid_i && req_ready_o; req_ready_o = !full. A push never occurs when full, even if a pop happens in the same cycle. Pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
- FSM states: IDLE, WAIT, RELEASE, RESP.
- IDLE, FIFO non-empty: pop the head and latch target/cmd/addr/data into current registers.
  - If target ≥ N_TARGETS or cmd == 0x00: status=10, data=0, go to RESP. No target sees any activity.
  - Otherwise: status=00, clear the counter, go to WAIT.
- WAIT: drive dbg_cmd_o[tgt]=cmd, addr, data; all other slices cmd=0, addr=0, data=0. The counter increments each cycle.
  - dbg_done_i[tgt]=1: capture dbg_data_i[tgt] into rsp data, clear the counter, go to RELEASE.
  - Else if counter == TIMEOUT-1: status=01, data=0, clear the counter, go to RELEASE.
  - Done in the same cycle as expiry: done wins, status 00.
- RELEASE: dbg_cmd_o[tgt]=0, addr/data held.
  - dbg_done_i[tgt]=0: go to RESP.
  - Else if counter == TIMEOUT-1: status=01 (data kept), go to RESP.
- RESP: rsp_valid_o=1 and all rsp_* outputs stable. On rsp_ready_i, go to IDLE.
- Only one command is outstanding at a time. Done inputs of non-selected targets are ignored.

## Timing
- Reset (rstn_i=0 at an edge): FSM=IDLE, FIFO empty, counter=0. Next cycle: req_ready_o=1, rsp_valid_o=0, rsp_* =0, all dbg_*_o=0. Reset mid-command drops the command and all queued requests.
- rsp_* outputs are registered. dbg_*_o outputs decode from registered state only; no combinational path from dbg_done_i.
- Minimum latency, with an empty FIFO and a target that raises done in its first WAIT cycle and drops it in its first RELEASE cycle:
  - acceptance edge E0; IDLE pops at E1; WAIT cycle ends at E2; RELEASE cycle ends at E3.
  - rsp_valid_o is high after E3.
- Timeout: exactly TIMEOUT cycles with cmd asserted, then RELEASE.
- Invalid request: rsp_valid_o is high after edge E1 (pop edge).
- Back-to-back: IDLE is re-entered the edge after the RESP handshake, with a one-cycle IDLE per command.

## Test plan
- Single read: N_TARGETS=2, target 1, cmd=0x01, addr=0x10; target returns done+data 0xDEADBEEF one cycle after cmd is seen, drops it one cycle later -> dbg_cmd_o slice 1 = 0x01 and slice 0 = 0x00 throughout; rsp status=00, target=1, data=0xDEADBEEF, rsp_valid high 3 edges after acceptance.
- Timeout: TIMEOUT=8, target never asserts done -> cmd held exactly 8 cycles, then response status=01, data=0.
- Invalid request: req_target_i=3 with N_TARGETS=3, then cmd=0x00 to target 0 -> two responses, both status=10, no nonzero dbg_cmd_o at any time.
- FIFO fill and backpressure: rsp_ready_i=0, push FIFO_DEPTH+2 requests -> req_ready_o drops after FIFO_DEPTH+1 accepted (one in flight). After rsp_ready_i=1, responses come back in order with matching targets.
- Reset mid-WAIT: assert rstn_i low for 1 cycle with 2 queued requests -> next cycle all dbg_cmd_o=0, rsp_valid_o=0, req_ready_o=1; no stale response afterward.
- Done on last timeout cycle (TIMEOUT=4, done in the 4th WAIT cycle) -> status=00 with captured data.

Source files
------------

// File: rtl/dbg_dispatch.sv
// dbg_dispatch: queues host debug requests and issues them one at a time
// to N debug targets, returning one response per request with a status code.
module dbg_dispatch #(
    parameter int BITSIZE    = 32,
    parameter int N_TARGETS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255,
    localparam int TW = ($clog2(N_TARGETS) > 0) ? $clog2(N_TARGETS) : 1
) (
    input  logic                           clk,
    input  logic                           rstn_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [TW-1:0]                  req_target_i,
    input  logic [7:0]                     req_cmd_i,
    input  logic [BITSIZE-1:0]             req_addr_i,
    input  logic [BITSIZE-1:0]             req_data_i,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [TW-1:0]                  rsp_target_o,
    output logic [1:0]                     rsp_status_o,
    output logic [BITSIZE-1:0]             rsp_data_o,
    output logic [8*N_TARGETS-1:0]         dbg_cmd_o,
    output logic [BITSIZE*N_TARGETS-1:0]   dbg_addr_o,
    output logic [BITSIZE*N_TARGETS-1:0]   dbg_data_o,
    input  logic [BITSIZE*N_TARGETS-1:0]   dbg_data_i,
    input  logic [N_TARGETS-1:0]           dbg_done_i
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam int EW = TW + 8 + 2 * BITSIZE;
    localparam int NV = 2 ** TW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_TMO = 2'b01;
    localparam logic [1:0] ST_INV = 2'b10;

    // request FIFO state
    logic [EW-1:0]      fifo_q [FIFO_DEPTH];
    logic [EW-1:0]      fifo_d [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW:0]        count_q, count_d;

    // current command and response state
    logic [1:0]         state_q, state_d;
    logic [TW-1:0]      tgt_q, tgt_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [BITSIZE-1:0] addr_q, addr_d;
    logic [BITSIZE-1:0] wdata_q, wdata_d;
    logic [BITSIZE-1:0] rdata_q, rdata_d;
    logic [1:0]         status_q, status_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               full;
    logic               push;
    logic               pop;
    logic [EW-1:0]      head;
    logic [TW-1:0]      h_tgt;
    logic [7:0]         h_cmd;
    logic [BITSIZE-1:0] h_addr;
    logic [BITSIZE-1:0] h_wdata;
    logic               h_bad;
    logic [NV-1:0]      tgt_ok;
    logic               sel_done;
    logic [BITSIZE-1:0] sel_data;
    logic               cnt_last;

    assign full        = (count_q == (PW+1)'(FIFO_DEPTH));
    assign req_ready_o = !full;
    assign push        = req_valid_i && !full;
    assign pop         = (state_q == S_IDLE) && (count_q != '0);
    assign head        = fifo_q[rd_ptr_q];
    assign h_tgt       = head[EW-1 -: TW];
    assign h_cmd       = head[2*BITSIZE +: 8];
    assign h_addr      = head[BITSIZE +: BITSIZE];
    assign h_wdata     = head[0 +: BITSIZE];
    assign cnt_last    = (cnt_q == CW'(TIMEOUT - 1));

    // table of which encodable target indices actually exist
    always_comb begin
        tgt_ok = '0;
        for (int i = 0; i < NV; i++) begin
            tgt_ok[i] = (i < N_TARGETS);
        end
    end

    assign h_bad = !tgt_ok[h_tgt] || (h_cmd == 8'h00);

    // done/data of the currently selected target; others are ignored
    always_comb begin
        sel_done = 1'b0;
        sel_data = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            if (tgt_q == TW'(i)) begin
                sel_done = dbg_done_i[i];
                sel_data = dbg_data_i[i*BITSIZE +: BITSIZE];
            end
        end
    end

    // FIFO pointer, count and storage next-state
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {req_target_i, req_cmd_i,
                                req_addr_i, req_data_i};
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    // command sequencing: issue, wait for done, wait for release, respond
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    tgt_d   = h_tgt;
                    cmd_d   = h_cmd;
                    addr_d  = h_addr;
                    wdata_d = h_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (h_bad) begin
                        status_d = ST_INV;
                        state_d  = S_RESP;
                    end else begin
                        status_d = ST_OK;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (sel_done) begin
                    rdata_d = sel_data;
                    cnt_d   = '0;
                    state_d = S_REL;
                end else if (cnt_last) begin
                    status_d = ST_TMO;
                    rdata_d  = '0;
                    cnt_d    = '0;
                    state_d  = S_REL;
                end
            end
            S_REL: begin
                cnt_d = cnt_q + CW'(1);
                if (!sel_done) begin
                    state_d = S_RESP;
                end else if (cnt_last) begin
                    status_d = ST_TMO;
                    state_d  = S_RESP;
                end
            end
            default: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // FIFO storage needs no reset; the count qualifies its contents
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    // control and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            tgt_q    <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rsp_valid_o  = (state_q == S_RESP);
    assign rsp_target_o = tgt_q;
    assign rsp_status_o = status_q;
    assign rsp_data_o   = rdata_q;

    // target channels decode from registered state only
    always_comb begin
        dbg_cmd_o  = '0;
        dbg_addr_o = '0;
        dbg_data_o = '0;
        for (int i = 0; i < N_TARGETS; i++) begin
            if (tgt_q == TW'(i)) begin
                if (state_q == S_WAIT) begin
                    dbg_cmd_o[8*i +: 8] = cmd_q;
                end
                if ((state_q == S_WAIT) || (state_q == S_REL)) begin
                    dbg_addr_o[i*BITSIZE +: BITSIZE] = addr_q;
                    dbg_data_o[i*BITSIZE +: BITSIZE] = wdata_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_dbg_dispatch.sv
// tb_dbg_dispatch: scoreboard bench with randomized host requests and
// behavioural debug targets driving done/data with per-request delays.
module tb_dbg_dispatch;

    localparam int BS = 32;
    localparam int NT = 3;
    localparam int FD = 4;
    localparam int TO = 8;
    localparam int TW = 2;

    logic              clk = 1'b0;
    logic              rstn_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [TW-1:0]     req_target_i;
    logic [7:0]        req_cmd_i;
    logic [BS-1:0]     req_addr_i;
    logic [BS-1:0]     req_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b1;
    logic [TW-1:0]     rsp_target_o;
    logic [1:0]        rsp_status_o;
    logic [BS-1:0]     rsp_data_o;
    logic [8*NT-1:0]   dbg_cmd_o;
    logic [BS*NT-1:0]  dbg_addr_o;
    logic [BS*NT-1:0]  dbg_data_o;
    logic [BS*NT-1:0]  dbg_data_i = '0;
    logic [NT-1:0]     dbg_done_i = '0;

    dbg_dispatch #(
        .BITSIZE(BS), .N_TARGETS(NT), .FIFO_DEPTH(FD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_target_i(req_target_i), .req_cmd_i(req_cmd_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_target_o(rsp_target_o), .rsp_status_o(rsp_status_o),
        .rsp_data_o(rsp_data_o),
        .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o),
        .dbg_data_o(dbg_data_o), .dbg_data_i(dbg_data_i),
        .dbg_done_i(dbg_done_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tgt;
        logic [1:0]    st;
        logic [BS-1:0] data;
    } rsp_t;

    typedef struct {
        int            t;
        logic [7:0]    cmd;
        logic [BS-1:0] addr;
        logic [BS-1:0] wdata;
        logic [BS-1:0] rdata;
        int            d;
        int            r;
    } par_t;

    rsp_t exp_q[$];
    par_t par_q[$];

    int checks = 0;
    int failures = 0;
    int ready_mode = 1;
    bit kill = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // reference: response from the request and the target's behaviour
    function automatic rsp_t model(input int t, input logic [7:0] cmd,
                                   input int d, input int r,
                                   input logic [BS-1:0] rd);
        rsp_t e;
        e.tgt = TW'(t);
        if (t >= NT || cmd == 8'h00) begin
            e.st = 2'b10; e.data = '0;
        end else if (d >= TO) begin
            e.st = 2'b01; e.data = '0;
        end else if (r >= TO) begin
            e.st = 2'b01; e.data = rd;
        end else begin
            e.st = 2'b00; e.data = rd;
        end
        return e;
    endfunction

    // host response-ready pattern
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: rsp_ready_i = 1'b0;
            1: rsp_ready_i = 1'b1;
            default: rsp_ready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    // behavioural targets: selected one follows its delays, others are noise
    int   found;
    int   act_t = -1;
    int   wcyc, rcyc, phase;
    bit   busy = 1'b0, raised, dn, own;
    par_t p;
    logic [31:0]    rnd;
    logic [NT-1:0]  nd;
    logic [BS*NT-1:0] ndat;

    always @(posedge clk) begin
        #1;
        rnd  = $urandom;
        nd   = rnd[NT-1:0];
        ndat = {$urandom, $urandom, $urandom};
        own  = 1'b0;
        found = -1;
        for (int i = 0; i < NT; i++)
            if (dbg_cmd_o[8*i +: 8] != 8'h00) found = i;
        if (kill) begin
            busy = 1'b0;
            dn   = 1'b0;
        end else begin
            if (!busy && found >= 0) begin
                busy = 1'b1; act_t = found;
                wcyc = 0; raised = 1'b0; phase = 0;
                if (par_q.size() == 0) begin
                    chk("unexpected_cmd", 64'(found), 64'hFFFF);
                    p.t = found; p.cmd = dbg_cmd_o[8*found +: 8];
                    p.d = 1000; p.r = 0; p.rdata = '0;
                    p.addr = '0; p.wdata = '0;
                end else begin
                    p = par_q.pop_front();
                    chk("cmd_target", 64'(found), 64'(p.t));
                    chk("cmd_value", dbg_cmd_o[8*found +: 8], p.cmd);
                    chk("cmd_addr", dbg_addr_o[BS*found +: BS], p.addr);
                    chk("cmd_wdata", dbg_data_o[BS*found +: BS], p.wdata);
                end
            end
            if (busy) begin
                own = 1'b1;
                if (phase == 0) begin
                    if (dbg_cmd_o[8*act_t +: 8] != 8'h00) begin
                        dn = (wcyc >= p.d);
                        raised |= dn;
                        wcyc++;
                    end else begin
                        chk("wait_cycles", 64'(wcyc),
                            64'((p.d < TO) ? p.d + 1 : TO));
                        phase = 1; rcyc = 0;
                    end
                end
                if (phase == 1) begin
                    dn = raised && (rcyc < p.r);
                    rcyc++;
                    if (!dn) busy = 1'b0;
                end
            end
        end
        if (own) begin
            nd[act_t] = dn;
            if (dn) ndat[BS*act_t +: BS] = p.rdata;
        end
        dbg_done_i = nd;
        dbg_data_i = ndat;
    end

    // monitor: response scoreboard plus per-cycle channel isolation
    int nz;
    always @(negedge clk) begin
        if (rstn_i === 1'b1) begin
            nz = 0;
            for (int i = 0; i < NT; i++) begin
                if (dbg_cmd_o[8*i +: 8] != 8'h00) nz++;
                if (i != act_t) begin
                    chk("idle_cmd", dbg_cmd_o[8*i +: 8], 0);
                    chk("idle_addr", dbg_addr_o[BS*i +: BS], 0);
                    chk("idle_wdata", dbg_data_o[BS*i +: BS], 0);
                end
            end
            chk("one_cmd", 64'(nz > 1), 0);
            if (rsp_valid_o && rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(rsp_status_o), 64'hFF);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_target", rsp_target_o, e.tgt);
                    chk("rsp_status", rsp_status_o, e.st);
                    chk("rsp_data", rsp_data_o, e.data);
                end
            end
        end
    end

    task automatic send(input int t, input logic [7:0] cmd,
                        input logic [BS-1:0] addr,
                        input logic [BS-1:0] wd,
                        input logic [BS-1:0] rd,
                        input int d, input int r);
        int n;
        par_t q;
        req_target_i = TW'(t);
        req_cmd_i    = cmd;
        req_addr_i   = addr;
        req_data_i   = wd;
        req_valid_i  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            chk("req_accept_timeout", 64'(req_ready_o), 1);
            req_valid_i = 1'b0;
            return;
        end
        exp_q.push_back(model(t, cmd, d, r, rd));
        if (t < NT && cmd != 8'h00) begin
            q.t = t; q.cmd = cmd; q.addr = addr; q.wdata = wd;
            q.rdata = rd; q.d = d; q.r = r;
            par_q.push_back(q);
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic latency(input string nm, input int exp);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!rsp_valid_o && n < 50);
        chk(nm, 64'(n), 64'(exp));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid_o) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_req_ready"}, req_ready_o, 1);
        chk({pfx, "_rsp_valid"}, rsp_valid_o, 0);
        chk({pfx, "_dbg_cmd"}, 64'(dbg_cmd_o), 0);
        chk({pfx, "_dbg_addr"}, 64'(|dbg_addr_o), 0);
        chk({pfx, "_dbg_data"}, 64'(|dbg_data_o), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale, t, d, r, g;
        logic [7:0] c;
        rstn_i = 1'b0;
        req_valid_i = 1'b0;
        req_target_i = '0;
        req_cmd_i = '0;
        req_addr_i = '0;
        req_data_i = '0;
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_rsp_target", rsp_target_o, 0);
        chk("reset_rsp_status", rsp_status_o, 0);
        chk("reset_rsp_data", rsp_data_o, 0);
        @(posedge clk);
        #1;

        send(1, 8'h01, 32'h10, $urandom, 32'hDEADBEEF, 0, 0);
        latency("read_latency", 3);
        drain();

        send(0, 8'h05, $urandom, $urandom, $urandom, 1000, 0);
        drain();

        send(2, 8'h02, $urandom, $urandom, 32'hCAFE0007, TO - 1, 0);
        drain();

        send(1, 8'h03, $urandom, $urandom, 32'h0BADF00D, 1, TO);
        drain();

        send(3, 8'h01, $urandom, $urandom, 0, 0, 0);
        latency("invalid_tgt_latency", 1);
        drain();
        send(0, 8'h00, $urandom, $urandom, 0, 0, 0);
        latency("invalid_cmd_latency", 1);
        drain();

        ready_mode = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < FD + 1; k++)
            send(k % NT, 8'(k + 1), $urandom, $urandom, $urandom, 0, 0);
        @(negedge clk);
        chk("full_ready", req_ready_o, 0);
        repeat (10) @(negedge clk);
        chk("full_ready_hold", req_ready_o, 0);
        chk("full_rsp_held", rsp_valid_o, 1);
        ready_mode = 1;
        send(2, 8'h66, $urandom, $urandom, $urandom, 1, 1);
        drain();

        send(0, 8'h11, $urandom, $urandom, $urandom, 1000, 0);
        send(1, 8'h12, $urandom, $urandom, $urandom, 0, 0);
        send(2, 8'h13, $urandom, $urandom, $urandom, 0, 0);
        chk("pre_reset_wait", 64'(dbg_cmd_o[7:0]), 64'h11);
        kill = 1'b1;
        rstn_i = 1'b0;
        @(posedge clk);
        #1 rstn_i = 1'b1;
        exp_q.delete();
        par_q.delete();
        @(negedge clk);
        chk_reset_outputs("midreset");
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid_o || dbg_cmd_o != '0) stale++;
        end
        chk("no_stale", 64'(stale), 0);
        kill = 1'b0;
        @(posedge clk);
        #1;

        ready_mode = 2;
        for (int k = 0; k < 60; k++) begin
            g = $urandom_range(0, 2);
            repeat (g) @(posedge clk);
            #1;
            t = $urandom_range(0, 3);
            c = ($urandom_range(0, 7) == 0) ? 8'h00
                                             : 8'($urandom_range(1, 255));
            case ($urandom_range(0, 7))
                0: d = TO - 1;
                1: d = TO + 12;
                default: d = $urandom_range(0, 3);
            endcase
            r = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 2);
            send(t, c, $urandom, $urandom, $urandom, d, r);
        end
        drain();
        ready_mode = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
